// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the signed ALU and its testbench.
package alu_pkg;
    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_MUL    = 2'b00;
    localparam alu_op_t OP_ADD    = 2'b01;
    localparam alu_op_t OP_APPEND = 2'b10;
    localparam alu_op_t OP_SHIFT  = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;
endpackage

// File: rtl/alu_seq_param_if.sv
// alu_seq_param_if: operand-issue handshake plus result bus between the issue stage and the ALU.
interface alu_seq_param_if #(parameter int WIDTH = 8);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           ctrl;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   out;
    logic                 out_valid;

    modport master (output in_valid, ctrl, A, B, input in_ready, out, out_valid);
    modport slave  (input in_valid, ctrl, A, B, output in_ready, out, out_valid);
endinterface

// File: rtl/alu_mul_booth.sv
// alu_mul_booth: signed WIDTH x WIDTH multiplier, one radix-2 Booth step per cycle after start.
// ALU_MUL_FAST_EN replaces it with a combinational product and done == start.
module alu_mul_booth #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);
`ifdef ALU_MUL_FAST_EN
    logic signed [2*WIDTH-1:0] a_sx;
    logic signed [2*WIDTH-1:0] b_sx;
    logic                      unused_clk_rst;

    assign a_sx           = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx           = {{WIDTH{b[WIDTH-1]}}, b};
    assign product        = a_sx * b_sx;
    assign done           = start;
    assign unused_clk_rst = clk ^ rst;
`else
    localparam int CNT_W = $clog2(WIDTH);
    localparam int P_W   = 2*WIDTH + 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [P_W-1:0]   p_q, p_d;
    logic [P_W-1:0]   p_step;
    logic [WIDTH:0]   hi_sum;

    // Upper half is WIDTH+1 bits so subtracting the most negative multiplicand cannot overflow.
    always_comb begin
        case (p_q[1:0])
            2'b01:   hi_sum = p_q[P_W-1:WIDTH+1] + m_q;
            2'b10:   hi_sum = p_q[P_W-1:WIDTH+1] - m_q;
            default: hi_sum = p_q[P_W-1:WIDTH+1];
        endcase
        p_step = {hi_sum[WIDTH], hi_sum, p_q[WIDTH:1]};
    end

    assign done    = busy_q && (cnt_q == CNT_W'(WIDTH-1));
    assign product = p_step[2*WIDTH:1];

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        m_d    = m_q;
        p_d    = p_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            m_d    = {a[WIDTH-1], a};
            p_d    = {{(WIDTH+1){1'b0}}, b, 1'b0};
        end else if (busy_q) begin
            p_d   = p_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            m_q    <= '0;
            p_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            m_q    <= m_d;
            p_q    <= p_d;
        end
    end
`endif
endmodule

// File: rtl/alu_seq_param.sv
// alu_seq_param: handshaked signed ALU (MUL/ADD/APPEND/SHIFT) with a registered 2*WIDTH result.
// ALU_MUL_FAST_EN makes MUL single-cycle; otherwise MUL stalls input for WIDTH cycles.
//
// state   | meaning
// ST_IDLE | ready; non-MUL ops (and fast MUL) complete on the accepting edge
// ST_MUL  | iterative Booth multiply in flight, in_ready low
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_param_if.slave   bus
);
    logic [0:0]                state_q, state_d;
    logic [2*WIDTH-1:0]        out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready;
    logic                      accept;
    logic                      mul_start;
    logic                      mul_done;
    logic [2*WIDTH-1:0]        mul_product;
    logic [2*WIDTH-1:0]        alu_res;
    logic signed [2*WIDTH-1:0] base_sx;
    logic signed [2*WIDTH-1:0] b_sx;
    logic signed [2*WIDTH-1:0] shl;
    logic signed [2*WIDTH-1:0] shr;
    logic [WIDTH-1:0]          neg_b;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = bus.in_valid && in_ready;
    assign mul_start = accept && (bus.ctrl == OP_MUL);

    alu_mul_booth #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .a       (bus.A),
        .b       (bus.B),
        .start   (mul_start),
        .product (mul_product),
        .done    (mul_done)
    );

    // Shift amounts wider than the result fall out naturally: << gives 0, >>> gives sign fill.
    always_comb begin
        base_sx = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
        b_sx    = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
        neg_b   = -bus.B;
        shl     = base_sx << bus.B;
        shr     = base_sx >>> neg_b;
        case (bus.ctrl)
            OP_ADD:    alu_res = base_sx + b_sx;
            OP_APPEND: alu_res = {bus.A, bus.B};
            OP_SHIFT:  alu_res = bus.B[WIDTH-1] ? shr : shl;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (bus.ctrl != OP_MUL)) begin
                    out_d       = alu_res;
                    out_valid_d = 1'b1;
                end
`ifndef ALU_MUL_FAST_EN
                if (mul_start) begin
                    state_d = ST_MUL;
                end
`endif
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (mul_done) begin
            out_d       = mul_product;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed vectors, multi-cycle corner sequences and random ops vs. an arithmetic model.
module tb_alu_seq_param;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int WW = 2*W;
`ifdef ALU_MUL_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_seq_param_if #(.WIDTH(W)) bus ();

    alu_seq_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    c;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [WW-1:0] exp;
        string         nm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] ref_model(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint la;
        longint lb;
        longint r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (c)
            OP_MUL:    r = la * lb;
            OP_ADD:    r = la + lb;
            OP_APPEND: r = ((la & ((64'sd1 <<< W) - 1)) <<< W) | (lb & ((64'sd1 <<< W) - 1));
            default: begin
                if (lb >= 0)
                    r = (lb >= WW) ? 0 : la * (64'sd1 <<< lb);
                else if (-lb >= WW)
                    r = (la < 0) ? -1 : 0;
                else
                    r = la >>> (-lb);
            end
        endcase
        return WW'(r);
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [WW-1:0] exp, input string nm);
        int cyc;
        int lat_exp;
        lat_exp = (c == OP_MUL) ? MUL_LAT : 1;
        bus.in_valid = 1'b1;
        bus.ctrl     = c;
        bus.A        = a;
        bus.B        = b;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            step();
            cyc++;
        end
        chk({nm, " ready"}, 64'(bus.in_ready), 64'(1));
        step();
        bus.in_valid = 1'b0;
        bus.ctrl     = 2'($urandom);
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
        cyc = 1;
        while (!bus.out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        chk({nm, " out"}, 64'(bus.out), 64'(exp));
        chk({nm, " latency"}, 64'(cyc), 64'(lat_exp));
        step();
        chk({nm, " pulse_end"}, 64'(bus.out_valid), 64'(0));
        chk({nm, " hold"}, 64'(bus.out), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] e;
        logic [1:0]    c;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int            pulses;

        n_cmp = 0;
        n_err = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.ctrl     = 2'b00;
        bus.A        = '0;
        bus.B        = '0;

        repeat (3) step();
        chk("reset out", 64'(bus.out), 64'(0));
        chk("reset out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset in_ready", 64'(bus.in_ready), 64'(1));
        rst = 1'b1;
        step();

        vecs.push_back('{OP_ADD,    8'h80, 8'h80, 16'hFF00, "add_min"});
        vecs.push_back('{OP_ADD,    8'h7F, 8'h7F, 16'h00FE, "add_max"});
        vecs.push_back('{OP_ADD,    8'h7F, 8'h80, 16'hFFFF, "add_mix"});
        vecs.push_back('{OP_APPEND, 8'h5E, 8'h81, 16'h5E81, "append"});
        vecs.push_back('{OP_SHIFT,  8'hFD, 8'h02, 16'hFFF4, "shl_neg"});
        vecs.push_back('{OP_SHIFT,  8'hFD, 8'hFF, 16'hFFFE, "shr_neg1"});
        vecs.push_back('{OP_SHIFT,  8'h01, 8'h10, 16'h0000, "shl_16"});
        vecs.push_back('{OP_SHIFT,  8'hFF, 8'hEC, 16'hFFFF, "shr_20"});
        vecs.push_back('{OP_SHIFT,  8'h01, 8'h0F, 16'h8000, "shl_15"});
        vecs.push_back('{OP_SHIFT,  8'h40, 8'h7F, 16'h0000, "shl_127"});
        vecs.push_back('{OP_SHIFT,  8'h80, 8'h80, 16'hFFFF, "shr_128_neg"});
        vecs.push_back('{OP_SHIFT,  8'h05, 8'h80, 16'h0000, "shr_128_pos"});
        vecs.push_back('{OP_SHIFT,  8'h7F, 8'hFA, 16'h0001, "shr_6"});
        vecs.push_back('{OP_MUL,    8'h7F, 8'hFF, 16'hFF81, "mul_127_m1"});
        vecs.push_back('{OP_MUL,    8'h80, 8'h7F, 16'hC080, "mul_min_max"});
        vecs.push_back('{OP_MUL,    8'h80, 8'h80, 16'h4000, "mul_min_min"});
        vecs.push_back('{OP_MUL,    8'h00, 8'h80, 16'h0000, "mul_zero"});
        vecs.push_back('{OP_MUL,    8'h03, 8'hFB, 16'hFFF1, "mul_3_m5"});

        foreach (vecs[i]) run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

        // back-to-back non-MUL ops: one result pulse per cycle
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ctrl = (i % 2 == 0) ? OP_APPEND : OP_ADD;
            bus.A    = W'(8'h11 * (i + 1));
            bus.B    = W'(8'hF0 - i);
            e        = ref_model(bus.ctrl, bus.A, bus.B);
            step();
            chk($sformatf("b2b%0d valid", i), 64'(bus.out_valid), 64'(1));
            chk($sformatf("b2b%0d out", i), 64'(bus.out), 64'(e));
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b end valid", 64'(bus.out_valid), 64'(0));

        // MUL with in_valid held during busy: not queued, accepted only once ready returns
        bus.in_valid = 1'b1;
        bus.ctrl     = OP_MUL;
        bus.A        = 8'h80;
        bus.B        = 8'h80;
        step();
        bus.ctrl = OP_ADD;
        bus.A    = 8'h03;
        bus.B    = 8'h04;
`ifndef ALU_MUL_FAST_EN
        for (int k = 1; k <= W; k++) begin
            chk($sformatf("mul busy%0d in_ready", k), 64'(bus.in_ready), 64'(0));
            chk($sformatf("mul busy%0d out_valid", k), 64'(bus.out_valid), 64'(0));
            step();
        end
`endif
        chk("mul done valid", 64'(bus.out_valid), 64'(1));
        chk("mul done out", 64'(bus.out), 64'(16'h4000));
        chk("mul done in_ready", 64'(bus.in_ready), 64'(1));
        step();
        bus.in_valid = 1'b0;
        chk("post-mul add valid", 64'(bus.out_valid), 64'(1));
        chk("post-mul add out", 64'(bus.out), 64'(16'h0007));
        step();
        chk("post-mul add end", 64'(bus.out_valid), 64'(0));

        // reset in the middle of a multiply
        bus.in_valid = 1'b1;
        bus.ctrl     = OP_MUL;
        bus.A        = 8'h64;
        bus.B        = 8'hB3;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("midmul rst out", 64'(bus.out), 64'(0));
        chk("midmul rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("midmul rst in_ready", 64'(bus.in_ready), 64'(1));
        step();
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 2*W; k++) begin
            step();
            if (bus.out_valid) pulses++;
        end
        chk("midmul no stale pulse", 64'(pulses), 64'(0));
        chk("midmul ready after", 64'(bus.in_ready), 64'(1));
        chk("midmul out still 0", 64'(bus.out), 64'(0));

        for (int i = 0; i < 800; i++) begin
            c = 2'($urandom);
            a = rnd_opnd();
            b = rnd_opnd();
            run_op(c, a, b, ref_model(c, a, b), $sformatf("rand%0d op%0d", i, c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
